// File: rtl/cannon_pkg.sv
// Shared types and sprite-size helpers for the cannon laser pool.
package cannon_pkg;

  typedef struct packed {
    logic       active;
    logic [9:0] x;
    logic [9:0] y;
  } laser_slot_t;

  function automatic int laser_w(input int scaling);
    return 1 * scaling;
  endfunction

  function automatic int laser_h(input int scaling);
    return 4 * scaling;
  endfunction

endpackage

// File: rtl/laser_slot.sv
// One laser slot: position state, hit latch, per-frame motion/retire and pixel compare.
module laser_slot
  import cannon_pkg::*;
#(
  parameter int CANNON_Y     = 470,
  parameter int UPPER_BORDER = 100,
  parameter int SCALING      = 4,
  parameter int LASER_SPEED  = 6
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        tick,
  input  logic        load,
  input  logic [9:0]  load_x,
  input  logic        hit,
  input  logic [9:0]  hpos,
  input  logic [9:0]  vpos,
  output laser_slot_t slot,
  output logic        gfx
);

  localparam logic [10:0] RETIRE_Y = 11'(UPPER_BORDER + LASER_SPEED);
  localparam logic [10:0] W        = 11'(laser_w(SCALING));
  localparam logic [10:0] H        = 11'(laser_h(SCALING));

  laser_slot_t slot_reg;
  logic        hit_pending_reg;
  logic [10:0] h11, v11, x11, y11;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      slot_reg        <= '0;
      hit_pending_reg <= 1'b0;
    end else begin
      if (tick)
        hit_pending_reg <= 1'b0;
      else if (hit && slot_reg.active)
        hit_pending_reg <= 1'b1;

      if (tick) begin
        // A retired slot keeps its last x/y; only the active flag drops.
        if (slot_reg.active) begin
          if (hit_pending_reg || hit || ({1'b0, slot_reg.y} < RETIRE_Y))
            slot_reg.active <= 1'b0;
          else
            slot_reg.y <= slot_reg.y - 10'(LASER_SPEED);
        end else if (load) begin
          slot_reg <= '{active: 1'b1, x: load_x, y: 10'(CANNON_Y)};
        end
      end
    end
  end

  assign h11  = {1'b0, hpos};
  assign v11  = {1'b0, vpos};
  assign x11  = {1'b0, slot_reg.x};
  assign y11  = {1'b0, slot_reg.y};
  assign slot = slot_reg;
  assign gfx  = slot_reg.active && (h11 >= x11) && (h11 < x11 + W)
                                && (v11 >= y11) && (v11 < y11 + H);

endmodule

// File: rtl/cannon_laser_pool.sv
// Multi-shot laser manager: frame tick, shot latch, refire cooldown, slot allocation, gfx OR.
module cannon_laser_pool
  import cannon_pkg::*;
#(
  parameter int NUM_LASERS      = 4,
  parameter int CANNON_Y        = 470,
  parameter int UPPER_BORDER    = 100,
  parameter int SCALING         = 4,
  parameter int LASER_SPEED     = 6,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [9:0]               vpos,
  input  logic [9:0]               hpos,
  input  logic                     vsync,
  input  logic                     shoot,
  input  logic [9:0]               cannon_x,
  input  logic [NUM_LASERS-1:0]    hit_alien,
  output logic [NUM_LASERS-1:0]    laser_active,
  output logic [NUM_LASERS*10-1:0] laser_x,
  output logic [NUM_LASERS*10-1:0] laser_y,
  output logic                     laser_gfx,
  output logic                     fire_pulse
);

  localparam int CD_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

  logic                  vsync_q_reg;
  logic                  vsync_armed_reg;
  logic                  shoot_pending_reg;
  logic                  fire_pulse_reg;
  logic [CD_W-1:0]       cooldown_reg;
  logic                  tick;
  logic                  fire;
  logic                  found;
  logic [NUM_LASERS-1:0] free_onehot;
  logic [NUM_LASERS-1:0] slot_gfx;

  // Armed only after vsync has been seen low, so a vsync already high at reset release is no edge.
  assign tick = vsync & ~vsync_q_reg & vsync_armed_reg;
  assign fire = tick & (shoot_pending_reg | shoot) & (cooldown_reg == '0) & ~(&laser_active);

  always_comb begin
    free_onehot = '0;
    found       = 1'b0;
    for (int i = 0; i < NUM_LASERS; i++) begin
      if (!laser_active[i] && !found) begin
        free_onehot[i] = 1'b1;
        found          = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      vsync_q_reg       <= 1'b0;
      vsync_armed_reg   <= 1'b0;
      shoot_pending_reg <= 1'b0;
      fire_pulse_reg    <= 1'b0;
      cooldown_reg      <= '0;
    end else begin
      vsync_q_reg <= vsync;
      if (!vsync)
        vsync_armed_reg <= 1'b1;

      if (tick)
        shoot_pending_reg <= 1'b0;
      else if (shoot)
        shoot_pending_reg <= 1'b1;

      fire_pulse_reg <= fire;

      if (fire)
        cooldown_reg <= CD_W'(COOLDOWN_FRAMES);
      else if (tick && (cooldown_reg != '0))
        cooldown_reg <= cooldown_reg - 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LASERS; gi++) begin : g_slot
      laser_slot_t slot;

      laser_slot #(
        .CANNON_Y    (CANNON_Y),
        .UPPER_BORDER(UPPER_BORDER),
        .SCALING     (SCALING),
        .LASER_SPEED (LASER_SPEED)
      ) u_slot (
        .clock  (clock),
        .reset_n(reset_n),
        .tick   (tick),
        .load   (fire & free_onehot[gi]),
        .load_x (cannon_x),
        .hit    (hit_alien[gi]),
        .hpos   (hpos),
        .vpos   (vpos),
        .slot   (slot),
        .gfx    (slot_gfx[gi])
      );

      assign laser_active[gi]       = slot.active;
      assign laser_x[gi*10 +: 10]   = slot.x;
      assign laser_y[gi*10 +: 10]   = slot.y;
    end
  endgenerate

  assign laser_gfx  = |slot_gfx;
  assign fire_pulse = fire_pulse_reg;

endmodule

// File: tb/tb_cannon_laser_pool.sv
// Directed bench for cannon_laser_pool with a frame-level reference model and scoreboard queue.
module tb_cannon_laser_pool;

  localparam int N   = 4;
  localparam int CD  = 8;
  localparam int CY  = 470;
  localparam int UB  = 100;
  localparam int SPD = 6;

  logic             clock = 1'b0;
  logic             reset_n, reset1_n;
  logic [9:0]       vpos, hpos, cannon_x;
  logic             vsync, shoot;
  logic [N-1:0]     hit_alien, laser_active;
  logic [N*10-1:0]  laser_x, laser_y;
  logic             laser_gfx, fire_pulse;
  logic [0:0]       hit1, act1;
  logic [9:0]       x1, y1;
  logic             gfx1, fire1;

  always #5 clock = ~clock;

  cannon_laser_pool #(.NUM_LASERS(N), .COOLDOWN_FRAMES(CD)) dut (
    .clock(clock), .reset_n(reset_n), .vpos(vpos), .hpos(hpos), .vsync(vsync),
    .shoot(shoot), .cannon_x(cannon_x), .hit_alien(hit_alien),
    .laser_active(laser_active), .laser_x(laser_x), .laser_y(laser_y),
    .laser_gfx(laser_gfx), .fire_pulse(fire_pulse)
  );

  cannon_laser_pool #(.NUM_LASERS(1), .COOLDOWN_FRAMES(0)) dut1 (
    .clock(clock), .reset_n(reset1_n), .vpos(vpos), .hpos(hpos), .vsync(vsync),
    .shoot(shoot), .cannon_x(cannon_x), .hit_alien(hit1),
    .laser_active(act1), .laser_x(x1), .laser_y(y1),
    .laser_gfx(gfx1), .fire_pulse(fire1)
  );

  typedef struct {
    bit              fire;
    logic [N-1:0]    act;
    logic [N*10-1:0] xs;
    logic [N*10-1:0] ys;
    bit              fire1;
    bit              act1;
    logic [9:0]      x1e;
    logic [9:0]      y1e;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  bit m_act[N];
  int m_x[N], m_y[N];
  bit m_hit[N];
  int m_cd;
  bit m_pend;
  bit m1_on, m1_act, m1_hit, m1_pend;
  int m1_x, m1_y;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_tick(input int cx, output exp_t e);
    logic [N-1:0] free_before;
    bit           fire;
    int           slot;
    for (int i = 0; i < N; i++) free_before[i] = !m_act[i];
    for (int i = 0; i < N; i++)
      if (m_act[i]) begin
        if (m_hit[i] || m_y[i] < UB + SPD) m_act[i] = 1'b0;
        else m_y[i] -= SPD;
      end
    fire = m_pend && (m_cd == 0) && (free_before != '0);
    if (fire) begin
      slot = 0;
      for (int i = N - 1; i >= 0; i--) if (free_before[i]) slot = i;
      m_act[slot] = 1'b1; m_x[slot] = cx; m_y[slot] = CY; m_cd = CD;
    end else if (m_cd > 0) m_cd--;
    m_pend = 1'b0;
    for (int i = 0; i < N; i++) m_hit[i] = 1'b0;
    e.fire = fire;
    for (int i = 0; i < N; i++) begin
      e.act[i]          = m_act[i];
      e.xs[i*10 +: 10]  = 10'(m_x[i]);
      e.ys[i*10 +: 10]  = 10'(m_y[i]);
    end
    // Single-slot, zero-cooldown instance: fires whenever its slot was free before the tick.
    e.fire1 = 1'b0;
    if (m1_on) begin
      if (m1_act) begin
        if (m1_hit || m1_y < UB + SPD) m1_act = 1'b0;
        else m1_y -= SPD;
      end else if (m1_pend) begin
        m1_act = 1'b1; m1_x = cx; m1_y = CY; e.fire1 = 1'b1;
      end
      m1_pend = 1'b0; m1_hit = 1'b0;
    end
    e.act1 = m1_act;
    e.x1e  = 10'(m1_x);
    e.y1e  = 10'(m1_y);
  endtask

  task automatic frame(input string tag, input bit sh, input logic [N-1:0] hm,
                       input bit h1m, input logic [9:0] cx);
    exp_t e, want;
    @(negedge clock);
    vsync = 1'b0; shoot = sh; cannon_x = cx;
    if (sh) begin m_pend = 1'b1; if (m1_on) m1_pend = 1'b1; end
    repeat (3) @(negedge clock);
    hit_alien = hm; hit1 = h1m;
    for (int i = 0; i < N; i++) if (hm[i] && m_act[i]) m_hit[i] = 1'b1;
    if (h1m && m1_on && m1_act) m1_hit = 1'b1;
    @(negedge clock);
    hit_alien = '0; hit1 = 1'b0;
    repeat (3) @(negedge clock);
    model_tick(int'(cx), e);
    sb.push_back(e);
    vsync = 1'b1;
    @(negedge clock);
    shoot = 1'b0;
    want = sb.pop_front();
    chk({tag, ".fire"}, 64'(fire_pulse), 64'(want.fire));
    chk({tag, ".act"},  64'(laser_active), 64'(want.act));
    chk({tag, ".x"},    64'(laser_x), 64'(want.xs));
    chk({tag, ".y"},    64'(laser_y), 64'(want.ys));
    if (m1_on) begin
      chk({tag, ".fire1"}, 64'(fire1), 64'(want.fire1));
      chk({tag, ".act1"},  64'(act1), 64'(want.act1));
      chk({tag, ".x1"},    64'(x1), 64'(want.x1e));
      chk({tag, ".y1"},    64'(y1), 64'(want.y1e));
    end
    @(negedge clock);
    chk({tag, ".pulse_end"}, 64'(fire_pulse), 64'(0));
    if (m1_on) chk({tag, ".pulse1_end"}, 64'(fire1), 64'(0));
    $display("frame %s: shoot=%0b fire=%0b active=%b", tag, sh, want.fire, want.act);
  endtask

  function automatic bit model_gfx(input int h, input int v);
    bit g = 1'b0;
    for (int i = 0; i < N; i++)
      if (m_act[i] && h >= m_x[i] && h < m_x[i] + 4 && v >= m_y[i] && v < m_y[i] + 16) g = 1'b1;
    return g;
  endfunction

  task automatic gfx_sweep(input string tag, input int h0, input int h1, input int v0, input int v1);
    for (int h = h0; h <= h1; h++)
      for (int v = v0; v <= v1; v++) begin
        @(negedge clock);
        hpos = 10'(h); vpos = 10'(v);
        #1;
        chk($sformatf("%s.h%0d.v%0d", tag, h, v), 64'(laser_gfx), 64'(model_gfx(h, v)));
      end
    $display("gfx sweep %s: h %0d..%0d v %0d..%0d", tag, h0, h1, v0, v1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; reset1_n = 1'b0;
    vsync = 1'b0; shoot = 1'b1; cannon_x = 10'd320;
    hpos = 10'd320; vpos = 10'd470; hit_alien = '0; hit1 = 1'b0;
    m_cd = 0; m_pend = 1'b0;
    m1_on = 1'b0; m1_act = 1'b0; m1_hit = 1'b0; m1_pend = 1'b0; m1_x = 0; m1_y = 0;
    for (int i = 0; i < N; i++) begin m_act[i] = 1'b0; m_x[i] = 0; m_y[i] = 0; m_hit[i] = 1'b0; end

    // Reset with shoot high and vsync toggling: nothing may appear.
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      vsync = ((c / 3) % 2) == 1;
      chk("rst.act",  64'(laser_active), 64'(0));
      chk("rst.xy",   64'({laser_x, laser_y}), 64'(0));
      chk("rst.fire", 64'(fire_pulse), 64'(0));
      chk("rst.gfx",  64'(laser_gfx), 64'(0));
    end
    $display("reset phase: outputs held at zero");
    @(negedge clock);
    vsync = 1'b0; reset_n = 1'b1; m_pend = 1'b1;

    frame("f1", 1'b1, '0, 1'b0, 10'd320);
    gfx_sweep("g1h", 316, 326, 475, 475);
    gfx_sweep("g1v", 321, 321, 468, 487);
    frame("f2", 1'b1, '0, 1'b0, 10'd302);
    gfx_sweep("g2v", 320, 320, 462, 481);

    for (int f = 3; f <= 37; f++)
      frame($sformatf("f%0d", f), 1'b1, '0, 1'b0, 10'(300 + f));
    frame("f38", 1'b0, '0, 1'b0, 10'd500);
    frame("f39", 1'b0, '0, 1'b0, 10'd500);
    frame("f40_retire_vs_fire", 1'b1, 4'b0100, 1'b0, 10'd600);
    frame("f41_reload", 1'b1, '0, 1'b0, 10'd1021);
    gfx_sweep("g41edge", 1017, 1023, 475, 475);
    for (int f = 42; f <= 44; f++)
      frame($sformatf("f%0d", f), 1'b0, '0, 1'b0, 10'd100);
    frame("f45_hit1", 1'b0, 4'b0010, 1'b0, 10'd100);
    frame("f46", 1'b0, '0, 1'b0, 10'd100);
    frame("f47_hit_idle", 1'b0, 4'b0010, 1'b0, 10'd100);
    for (int f = 48; f <= 66; f++)
      frame($sformatf("f%0d", f), 1'b0, '0, 1'b0, 10'd100);

    // Release the single-slot instance while vsync is already high.
    @(negedge clock);
    shoot = 1'b1; reset1_n = 1'b1; m1_on = 1'b1; m1_pend = 1'b1; m_pend = 1'b1;
    repeat (2) begin
      @(negedge clock);
      chk("rel.fire1", 64'(fire1), 64'(0));
      chk("rel.act1",  64'(act1), 64'(0));
    end
    shoot = 1'b0;
    $display("single-slot release with vsync high: no tick");

    frame("s1_fire", 1'b0, '0, 1'b0, 10'd200);
    frame("s2_busy", 1'b1, '0, 1'b0, 10'd210);
    frame("s3_hit", 1'b1, '0, 1'b1, 10'd220);
    frame("s4_refire", 1'b1, '0, 1'b0, 10'd230);
    frame("s5_busy", 1'b1, '0, 1'b0, 10'd240);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cannon_laser_pool.md
# cannon_laser_pool

Multi-shot player laser manager for the cannon. It holds `NUM_LASERS` independent laser slots that advance once per video frame, and adds a refire cooldown and per-slot hit retirement. It generates a combined pixel mask for the video mixer. It sits between the cannon controller (which supplies `shoot` and `cannon_x`) and the alien collision logic (which returns per-slot `hit_alien`). All logic runs on the pixel clock; `vsync` is sampled as data, not used as a clock.

## Interface
Parameters:
- `NUM_LASERS`, default 4: number of simultaneous laser slots (1–8).
- `CANNON_Y`, default 470: y loaded into a slot when it fires.
- `UPPER_BORDER`, default 100: a slot retires instead of moving above this line.
- `SCALING`, default 4: sprite scale; laser is `1*SCALING` wide and `4*SCALING` tall.
- `LASER_SPEED`, default 6: pixels moved up per frame.
- `COOLDOWN_FRAMES`, default 8: frames between successive shots; 0 allows a shot every frame.

Ports:
- `clock` in 1: pixel clock.
- `reset_n` in 1: reset, synchronous, active-low.
- `vpos` in 10: current beam line.
- `hpos` in 10: current beam column.
- `vsync` in 1: vertical sync level; its rising edge is the frame tick.
- `shoot` in 1: fire request level, sampled every cycle.
- `cannon_x` in 10: cannon x position, sampled on the frame tick.
- `hit_alien` in NUM_LASERS: per-slot collision pulse, valid any cycle.
- `laser_active` out NUM_LASERS: slot in flight.
- `laser_x` out NUM_LASERS×10 (packed, slot 0 in LSBs): slot x.
- `laser_y` out NUM_LASERS×10 (packed): slot y.
- `laser_gfx` out 1: beam is inside any active laser.
- `fire_pulse` out 1: one-cycle strobe when a slot fires (for sound).

## Operation
- Frame tick: `tick = vsync & ~vsync_q`, where `vsync_q` is `vsync` registered. All motion, fire and cooldown updates happen only on the tick edge.
- Request latch:
  - `shoot_pending` is set on any cycle with `shoot=1`.
  - It is cleared on every tick, whether or not a shot fires. Requests that cannot be served are dropped.
- Hit latch: `hit_pending[i]` is set when `hit_alien[i]=1` and slot i is active. It is cleared on tick or reset. A hit arriving in the tick cycle itself counts.
- Per active slot i at tick:
  - If `hit_pending[i] | hit_alien[i]` or `laser_y[i] < UPPER_BORDER + LASER_SPEED`, clear `laser_active[i]`. x and y hold their last values.
  - Otherwise `laser_y[i] -= LASER_SPEED`. The guard ensures no underflow.
- Fire at tick:
  - Condition: `shoot_pending` (or `shoot` in the tick cycle) and `cooldown == 0` and at least one slot was inactive *before* this tick.
  - The lowest-index free slot is loaded with `x = cannon_x`, `y = CANNON_Y` and becomes active. It does not move on its firing tick.
  - A slot retired on this tick is not reusable until the next tick.
  - `cooldown` is loaded with `COOLDOWN_FRAMES`.
- Cooldown: on each tick with no fire, a nonzero `cooldown` decrements by 1. Width is `$clog2(COOLDOWN_FRAMES+1)`, minimum 1.
- Graphics: `laser_gfx` is the OR over slots of `active & hpos ∈ [x, x+1*SCALING) & vpos ∈ [y, y+4*SCALING)`. Compares are done in 11 bits so x or y near 1023 does not wrap.

## Timing
- Reset: all of the following go to 0 on the first clock edge with `reset_n=0`, independent of tick: `laser_active`, `laser_x`, `laser_y`, `cooldown`, `shoot_pending`, `hit_pending`, `vsync_q`, `fire_pulse`. `laser_gfx` is 0 as a consequence.
- Reset mid-flight: all slots vanish on the next edge. A `vsync` already high at reset release does not produce a tick until it falls and rises again.
- Update latency:
  - Tick is asserted in the cycle after `vsync` is first seen high; the state update is registered on that edge.
  - New `laser_*` values are visible the following cycle.
  - `fire_pulse` is high for exactly that one cycle.
- `laser_gfx` is combinational from registered state and `hpos`/`vpos`, with zero latency.
- Simultaneous events:
  - A fire and a retire in the same tick are both performed.
  - A hit on an inactive slot is ignored.

## Structure
- Package `cannon_pkg`: `LASER_W = 1*SCALING` and `LASER_H = 4*SCALING` helper functions, and a `laser_slot_t` struct `{active, x[9:0], y[9:0]}`.
- Sub-module `laser_slot`, one per slot via generate. It takes inputs `tick`, `load`, `load_x`, `hit`, `hpos`, `vpos` and holds the slot's state, hit latch, motion/retire logic and gfx compare.
- The top level holds the vsync edge detect, shoot latch, cooldown counter, lowest-free-slot priority encoder and the gfx OR.

## Test plan
- Reset with `shoot` held high and `vsync` toggling: all outputs stay 0 while `reset_n=0`. After release, the first rising edge of `vsync` fires slot 0 with `x=cannon_x=320`, `y=470` and `fire_pulse` high for 1 cycle.
- Single laser flight: after firing, y steps 470→464→…, one step per frame. Once y is below 106 it retires on the next tick, so the last active y is ≥100. `laser_gfx=1` exactly for hpos 320..323 and vpos y..y+15.
- Cooldown with `shoot` held and `COOLDOWN_FRAMES=8`: slots 0, 1, 2, 3 fire 9 frames apart. A 5th request with all slots busy is dropped: no `fire_pulse`, and cooldown keeps counting.
- One-cycle `hit_alien[1]` pulse mid-frame: slot 1 retires at the next tick while other slots keep moving. A hit pulse on an inactive slot has no effect.
- Same-tick retire and fire with all slots busy: slot 2 retires on the same tick as a request, so no fire occurs. On the next tick slot 2 is reloaded from `cannon_x`.
- `COOLDOWN_FRAMES=0`, `NUM_LASERS=1`: a laser fires on every frame where the slot was free before the tick.
